// File: rtl/speck_pkg.sv
// Shared definitions for the iterative SPECK core: FSM encoding,
// the SPECK128/128 default parameter set and width-generic rotates.
package speck_pkg;

  // Widest word the rotate helpers handle; narrower words are zero-padded.
  localparam int unsigned MAX_N = 64;

  // SPECK128/128 default parameter set.
  localparam int unsigned SPECK128_N     = 64;
  localparam int unsigned SPECK128_M     = 2;
  localparam int unsigned SPECK128_T     = 32;
  localparam int unsigned SPECK128_ALPHA = 8;
  localparam int unsigned SPECK128_BETA  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_KEYEXP = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Mask selecting the low w bits of a MAX_N-wide value.
  function automatic logic [MAX_N-1:0] width_mask(input int unsigned w);
    return (w >= MAX_N) ? {MAX_N{1'b1}} : ((MAX_N'(1) << w) - MAX_N'(1));
  endfunction

  // Rotate the low w bits of v left by s (0 <= s < w); upper bits return 0.
  function automatic logic [MAX_N-1:0] rol(input logic [MAX_N-1:0] v,
                                           input int unsigned s,
                                           input int unsigned w);
    logic [MAX_N-1:0] vm;
    vm = v & width_mask(w);
    return ((vm << s) | (vm >> (w - s))) & width_mask(w);
  endfunction

  // Rotate the low w bits of v right by s (0 < s < w).
  function automatic logic [MAX_N-1:0] ror(input logic [MAX_N-1:0] v,
                                           input int unsigned s,
                                           input int unsigned w);
    return rol(v, w - s, w);
  endfunction

endpackage

// File: rtl/speck_round_unit.sv
// One SPECK round, combinational, in either direction. The key schedule
// drives the encrypt path with (l, k, i) as (x, y, key).
module speck_round_unit
  import speck_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned ALPHA = 8,
  parameter int unsigned BETA  = 3
) (
  input  logic         mode_i,   // 0 = encrypt, 1 = decrypt
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] k_i,
  output logic [N-1:0] x_o,
  output logic [N-1:0] y_o
);

  logic [N-1:0] enc_x, enc_y, dec_x, dec_y;

  // Encrypt: x = (ROR(x,a) + y) ^ k ; y = ROL(y,b) ^ x
  assign enc_x = (N'(ror(MAX_N'(x_i), ALPHA, N)) + y_i) ^ k_i;
  assign enc_y = N'(rol(MAX_N'(y_i), BETA, N)) ^ enc_x;

  // Decrypt: y = ROR(x ^ y, b) ; x = ROL((x ^ k) - y, a)
  assign dec_y = N'(ror(MAX_N'(x_i ^ y_i), BETA, N));
  assign dec_x = N'(rol(MAX_N'((x_i ^ k_i) - dec_y), ALPHA, N));

  assign x_o = mode_i ? dec_x : enc_x;
  assign y_o = mode_i ? dec_y : enc_y;

endmodule

// File: rtl/speck_iterative_core.sv
// Iterative SPECK core: expands the key once into a round-key cache, then
// runs one round per clock through a single shared round unit.
module speck_iterative_core
  import speck_pkg::*;
#(
  parameter int unsigned WORD_SIZE = SPECK128_N,
  parameter int unsigned KEY_WORDS = SPECK128_M,
  parameter int unsigned NR_ROUNDS = SPECK128_T,
  parameter int unsigned ALPHA     = SPECK128_ALPHA,
  parameter int unsigned BETA      = SPECK128_BETA
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           mode,
  input  logic                           key_load,
  input  logic [KEY_WORDS*WORD_SIZE-1:0] key,
  input  logic [2*WORD_SIZE-1:0]         din,
  output logic [2*WORD_SIZE-1:0]         dout,
  output logic                           done,
  output logic                           busy,
  output logic                           key_ready
);

  localparam int unsigned N    = WORD_SIZE;
  localparam int unsigned M    = KEY_WORDS;
  localparam int unsigned T    = NR_ROUNDS;
  localparam int unsigned LW   = M - 1;
  localparam int unsigned CW   = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] LAST = CW'(T - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   mode_q;
  logic [N-1:0]           x_q, y_q, k_q;
  logic [LW-1:0][N-1:0]   l_q;
  logic [N-1:0]           cache_q [T];
  logic [2*N-1:0]         dout_q;
  logic                   done_q, key_ready_q;

  logic                   need_exp, last_cyc;
  logic [CW-1:0]          rd_addr;
  logic                   ru_mode;
  logic [N-1:0]           ru_x, ru_y, ru_k, ru_xo, ru_yo;

  assign need_exp = key_load || !key_ready_q;
  assign last_cyc = (cnt_q == LAST);
  assign rd_addr  = mode_q ? (LAST - cnt_q) : cnt_q;

  // Round unit operands: key schedule in KEYEXP, cipher rounds in RUN.
  always_comb begin
    ru_mode = 1'b0;
    ru_x    = l_q[0];
    ru_y    = k_q;
    ru_k    = N'(cnt_q);
    if (state_q == S_RUN) begin
      ru_mode = mode_q;
      ru_x    = x_q;
      ru_y    = y_q;
      ru_k    = cache_q[rd_addr];
    end
  end

  speck_round_unit #(
    .N     (N),
    .ALPHA (ALPHA),
    .BETA  (BETA)
  ) u_round (
    .mode_i (ru_mode),
    .x_i    (ru_x),
    .y_i    (ru_y),
    .k_i    (ru_k),
    .x_o    (ru_xo),
    .y_o    (ru_yo)
  );

  // Next-state and counter; the counter wraps to 0 when leaving KEYEXP/RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = need_exp ? S_KEYEXP : S_RUN;
          cnt_d   = '0;
        end
      end
      S_KEYEXP: begin
        if (last_cyc) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (last_cyc) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and round counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture, key-schedule registers, cipher state and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= '0;
      l_q         <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            x_q    <= din[2*N-1:N];
            y_q    <= din[N-1:0];
            k_q    <= key[N-1:0];
            for (int j = 0; j < LW; j++) l_q[j] <= key[(j+1)*N +: N];
            // The cache is about to be overwritten.
            if (need_exp) key_ready_q <= 1'b0;
          end
        end
        S_KEYEXP: begin
          k_q <= ru_yo;
          for (int j = 0; j < LW - 1; j++) l_q[j] <= l_q[j+1];
          l_q[LW-1] <= ru_xo;
          if (last_cyc) key_ready_q <= 1'b1;
        end
        S_RUN: begin
          x_q <= ru_xo;
          y_q <= ru_yo;
          if (last_cyc) begin
            dout_q <= {ru_xo, ru_yo};
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-key cache: one write per KEYEXP cycle, contents not reset.
  always_ff @(posedge clk) begin
    if (state_q == S_KEYEXP) cache_q[cnt_q] <= k_q;
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign busy      = (state_q == S_KEYEXP) || (state_q == S_RUN);
  assign key_ready = key_ready_q;

endmodule

// File: tb/tb_speck_iterative_core.sv
// Directed bench for speck_iterative_core: SPECK128/128 vectors, reset
// abort, held start, random round trips and a SPECK32/64 instance.
module tb_speck_iterative_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         start = 1'b0, mode = 1'b0, key_load = 1'b0;
  logic [127:0] key = '0, din = '0;
  logic [127:0] dout;
  logic         done, busy, key_ready;

  logic         s_start = 1'b0, s_mode = 1'b0, s_kl = 1'b0;
  logic [63:0]  s_key = '0;
  logic [31:0]  s_din = '0;
  logic [31:0]  s_dout;
  logic         s_done, s_busy, s_kr;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] P0 = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] C0 = 128'ha65d985179783265_7860fedf5c570d18;

  always #5 clk = ~clk;

  speck_iterative_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_load(key_load),
    .key(key), .din(din), .dout(dout), .done(done), .busy(busy), .key_ready(key_ready)
  );

  speck_iterative_core #(
    .WORD_SIZE(16), .KEY_WORDS(4), .NR_ROUNDS(22), .ALPHA(7), .BETA(2)
  ) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .key_load(s_kl),
    .key(s_key), .din(s_din), .dout(s_dout), .done(s_done), .busy(s_busy), .key_ready(s_kr)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Plain SPECK128/128 reference encryption.
  function automatic logic [127:0] ref_enc(input logic [127:0] k128, input logic [127:0] pt);
    logic [63:0] k, l, x, y;
    k = k128[63:0]; l = k128[127:64]; x = pt[127:64]; y = pt[63:0];
    for (int i = 0; i < 32; i++) begin
      x = ({x[7:0], x[63:8]} + y) ^ k;
      y = {y[60:0], y[63:61]} ^ x;
      l = ({l[7:0], l[63:8]} + k) ^ 64'(i);
      k = {k[60:0], k[63:61]} ^ l;
    end
    return {x, y};
  endfunction

  // Issue one start on the 128-bit core; lat = negedges from the start edge
  // to the first done sample (0 on timeout). Inputs are scrambled afterwards.
  task automatic do_op(input logic [127:0] k, input logic [127:0] d, input logic m,
                       input logic kl, output logic [127:0] q, output int lat);
    lat = 0;
    q   = '0;
    @(negedge clk);
    start = 1'b1; key = k; din = d; mode = m; key_load = kl;
    for (int c = 1; c <= 300 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; mode = ~m; key_load = ~kl;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        din = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (done) begin lat = c; q = dout; end
    end
  endtask

  initial begin
    logic [127:0] q, ct, rk, rp;
    int lat, n_done, t1, t2, lowcnt, dcnt;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 128'h0);
    check("rst_done", 128'(done), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_key_ready", 128'(key_ready), 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Expand + encrypt
    do_op(K0, P0, 1'b0, 1'b1, q, lat);
    check("t1_latency", 128'(lat), 128'd65);
    check("t1_dout", q, C0);
    check("t1_key_ready", 128'(key_ready), 128'h1);
    @(negedge clk);
    check("t1_done_pulse", 128'(done), 128'h0);

    // 2. Decrypt with cached keys
    do_op(128'h0, C0, 1'b1, 1'b0, q, lat);
    check("t2_latency", 128'(lat), 128'd33);
    check("t2_dout", q, P0);

    // 3. Reset during RUN aborts; next start re-expands
    @(negedge clk);
    start = 1'b1; mode = 1'b0; key_load = 1'b0; key = K0; din = P0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t3_busy_after_rst", 128'(busy), 128'h0);
    check("t3_kr_after_rst", 128'(key_ready), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t3_no_done", 128'(dcnt), 128'h0);
    do_op(K0, P0, 1'b0, 1'b0, q, lat);
    check("t3_latency", 128'(lat), 128'd65);
    check("t3_dout", q, C0);

    // 4. start held high for 80 cycles
    @(negedge clk);
    start = 1'b1; mode = 1'b0; key_load = 1'b1; key = K0; din = P0;
    n_done = 0; t1 = 0; t2 = 0; lowcnt = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 80) start = 1'b0;
      if (done) begin
        n_done++;
        if (t1 == 0) t1 = c; else t2 = c;
        if (n_done == 2) ct = dout;
      end else if (t1 != 0 && n_done == 1 && !busy) begin
        lowcnt++;
      end
    end
    check("t4_done_count", 128'(n_done), 128'd2);
    check("t4_first_done", 128'(t1), 128'd65);
    check("t4_second_done", 128'(t2), 128'd131);
    check("t4_busy_low_cycles", 128'(lowcnt), 128'd1);
    check("t4_dout", ct, C0);

    // 5. Random round trips against the reference model
    for (int i = 0; i < 100; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_op(rk, rp, 1'b0, 1'b1, ct, lat);
      check("t5_enc", ct, ref_enc(rk, rp));
      do_op(128'h0, ct, 1'b1, 1'b0, q, lat);
      check("t5_dec", q, rp);
    end

    // 6. SPECK32/64
    @(negedge clk);
    s_start = 1'b1; s_mode = 1'b0; s_kl = 1'b1;
    s_key = 64'h1918_1110_0908_0100; s_din = 32'h6574_694c;
    lat = 0;
    for (int c = 1; c <= 200 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin s_start = 1'b0; s_key = 64'h0; s_din = 32'h0; end
      if (s_done) begin lat = c; ct = 128'(s_dout); end
    end
    check("t6_latency", 128'(lat), 128'd45);
    check("t6_dout", ct, 128'ha868_42f2);
    @(negedge clk);
    s_start = 1'b1; s_mode = 1'b1; s_kl = 1'b0; s_din = 32'ha868_42f2;
    lat = 0;
    for (int c = 1; c <= 200 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) s_start = 1'b0;
      if (s_done) begin lat = c; q = 128'(s_dout); end
    end
    check("t6_dec_latency", 128'(lat), 128'd23);
    check("t6_dec_dout", q, 128'h6574_694c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
